// File: rtl/uart_prog_loader_if.sv
// Instruction BRAM write port driven by the program loader.
// Handshake: i_we is a one-cycle valid strobe qualifying i_addr/i_wdata in the
// same cycle. The BRAM always accepts, so there is no ready; i_addr and
// i_wdata hold their last values between strobes.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;

  modport master (output i_we, output i_addr, output i_wdata);
  modport slave  (input  i_we, input  i_addr, input  i_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// Boot-time program loader: receives a length header and big-endian 32-bit
// words over 8N1 UART, writes them into the instruction BRAM, and holds the
// core in reset until the announced number of words has arrived.
module uart_prog_loader #(
  parameter int CLK_PER_BIT = 868,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  uart_prog_loader_if.master bram,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words,
  output logic [3:0]        dbg_state   // {loader state, rx state}
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [32:0]      DEPTH     = 33'd1 << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE} ld_state_t;

  // synchronizer
  logic rxd_s1_q, rxd_s2_q;

  // receiver
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // loader
  ld_state_t         ld_state_q, ld_state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       len_q, len_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       rcvd_q, rcvd_d;
  logic              i_we_q, i_we_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;
  logic [31:0]       i_wdata_q, i_wdata_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic              done_q, done_d;
  logic              core_rst_q, core_rst_d;
  logic              err_q, err_d;

  // Two-flop synchronizer; idle-high so reset to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // RX next state: half-bit start check, then mid-bit sampling of data and stop.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxd_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rxd_s2_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          byte_valid_d = rxd_s2_q;
          frame_err_d  = ~rxd_s2_q;
          rx_state_d   = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state and registered byte/error strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Loader next state: header, word assembly, BRAM write, overflow handling.
  // shreg_q still holds the received byte while byte_valid_q is high.
  always_comb begin
    ld_state_d = ld_state_q;
    bcnt_d     = bcnt_q;
    len_d      = len_q;
    word_d     = word_q;
    rcvd_d     = rcvd_q;
    i_we_d     = 1'b0;
    i_addr_d   = i_addr_q;
    i_wdata_d  = i_wdata_q;
    words_d    = words_q;
    done_d     = (ld_state_q == L_DONE);
    core_rst_d = (ld_state_q != L_DONE);
    err_d      = err_q | frame_err_q;
    case (ld_state_q)
      L_LEN: begin
        if (byte_valid_q) begin
          len_d  = {len_q[23:0], shreg_q};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            ld_state_d = ({len_q[23:0], shreg_q} == 32'd0) ? L_DONE : L_DATA;
          end
        end
      end
      L_DATA: begin
        if (byte_valid_q) begin
          word_d = {word_q[15:0], shreg_q};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            rcvd_d = rcvd_q + 32'd1;
            // Words past the BRAM depth still count toward len, but are not written.
            if ({1'b0, rcvd_q} < DEPTH) begin
              i_we_d    = 1'b1;
              i_addr_d  = words_q;
              i_wdata_d = {word_q, shreg_q};
            end else begin
              err_d = 1'b1;
            end
            if (words_q != {ADDR_W{1'b1}}) words_d = words_q + 1'b1;
            if (rcvd_q + 32'd1 == len_q) ld_state_d = L_DONE;
          end
        end
      end
      L_DONE: ;
      default: ld_state_d = L_LEN;
    endcase
  end

  // Loader state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_q <= L_LEN;
      bcnt_q     <= '0;
      len_q      <= '0;
      word_q     <= '0;
      rcvd_q     <= '0;
      i_we_q     <= 1'b0;
      i_addr_q   <= '0;
      i_wdata_q  <= '0;
      words_q    <= '0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      bcnt_q     <= bcnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      rcvd_q     <= rcvd_d;
      i_we_q     <= i_we_d;
      i_addr_q   <= i_addr_d;
      i_wdata_q  <= i_wdata_d;
      words_q    <= words_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
      err_q      <= err_d;
    end
  end

  assign bram.i_we    = i_we_q;
  assign bram.i_addr  = i_addr_q;
  assign bram.i_wdata = i_wdata_q;
  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words        = words_q;
  assign dbg_state    = {ld_state_q, rx_state_q};

endmodule
